// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache maintenance controller:
// CHCW field layout, tag entry format and default geometry.
package icache_pkg;

    localparam int TAGAW_DEF = 7;
    localparam int TAGW_DEF  = 28;
    localparam int CNTW_DEF  = 12;

    localparam int CHCW_ICC_BIT = 0;
    localparam int CHCW_ICE_BIT = 1;
    localparam int CHCW_CEC_LSB = 8;
    localparam int CHCW_CEN_LSB = 20;

    typedef struct packed {
        logic [11:0] cen;
        logic [11:0] cec;
        logic [5:0]  rsvd;
        logic        ice;
        logic        icc;
    } chcw_t;

    typedef struct packed {
        logic [3:0]  rsvd;
        logic [1:0]  valid;
        logic [21:0] tag;
    } itag_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CLEAR,
        S_DONE
    } maint_state_t;

endpackage

// File: rtl/icache_maint_ctl.sv
// I$ maintenance sequencer: owns CHCW, runs ICC clears over the tag RAM and
// arbitrates the tag write port between the clear walk and the fill engine.
module icache_maint_ctl
    import icache_pkg::*;
#(
    parameter int TAGAW = TAGAW_DEF,
    parameter int TAGW  = TAGW_DEF,
    parameter int CNTW  = CNTW_DEF
) (
    input  logic             CLK,
    input  logic             RESn,
    input  logic             CE,
    input  logic             chcw_we,
    input  logic [31:0]      chcw_wd,
    output logic [31:0]      chcw_rd,
    output logic             ice,
    output logic             icmaint,
    input  logic             fetch_req,
    output logic             fetch_gnt,
    input  logic             fill_busy,
    input  logic             fill_tag_we,
    input  logic [TAGAW-1:0] fill_tag_a,
    input  logic [TAGW-1:0]  fill_tag_d,
    output logic             tag_we,
    output logic [TAGAW-1:0] tag_a,
    output logic [TAGW-1:0]  tag_d
);

    maint_state_t    state_q, state_d;
    logic            ice_q, ice_d;
    logic            icc_q, icc_d;
    logic            clr_pend_q, clr_pend_d;
    logic            icmaint_q, icmaint_d;
    logic [CNTW-1:0] cen_q, cen_d;
    logic [CNTW-1:0] cec_q, cec_d;
    chcw_t           rd_fields;
    logic            unused_wd_rsvd;

    assign unused_wd_rsvd = ^chcw_wd[CHCW_CEC_LSB-1:CHCW_ICE_BIT+1];

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            state_q    <= S_IDLE;
            ice_q      <= 1'b0;
            icc_q      <= 1'b0;
            clr_pend_q <= 1'b0;
            icmaint_q  <= 1'b0;
            cen_q      <= '0;
            cec_q      <= '0;
        end else if (CE) begin
            state_q    <= state_d;
            ice_q      <= ice_d;
            icc_q      <= icc_d;
            clr_pend_q <= clr_pend_d;
            icmaint_q  <= icmaint_d;
            cen_q      <= cen_d;
            cec_q      <= cec_d;
        end
    end

    // The DONE bookkeeping is registered on the way into DONE, so a zero-length
    // clear holds icmaint for exactly one cycle.
    always_comb begin
        state_d    = state_q;
        ice_d      = ice_q;
        icc_d      = icc_q;
        clr_pend_d = clr_pend_q;
        icmaint_d  = icmaint_q;
        cen_d      = cen_q;
        cec_d      = cec_q;
        if (chcw_we) begin
            ice_d = chcw_wd[CHCW_ICE_BIT];
        end
        case (state_q)
            S_IDLE: begin
                if (chcw_we && chcw_wd[CHCW_ICC_BIT]) begin
                    cen_d      = chcw_wd[CHCW_CEN_LSB +: CNTW];
                    cec_d      = chcw_wd[CHCW_CEC_LSB +: CNTW];
                    icc_d      = 1'b1;
                    clr_pend_d = 1'b1;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!fill_busy && !fill_tag_we) begin
                    icmaint_d = 1'b1;
                    state_d   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (cec_q != '0) begin
                    cen_d = cen_q + CNTW'(1);
                    cec_d = cec_q - CNTW'(1);
                end else begin
                    icc_d      = 1'b0;
                    cen_d      = '0;
                    cec_d      = '0;
                    icmaint_d  = 1'b0;
                    clr_pend_d = 1'b0;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The clear walk owns the tag port outright; a stray fill write is dropped.
    always_comb begin
        tag_we = fill_tag_we;
        tag_a  = fill_tag_a;
        tag_d  = fill_tag_d;
        if (state_q == S_CLEAR) begin
            tag_we = CE && (cec_q != '0);
            tag_a  = cen_q[TAGAW-1:0];
            tag_d  = '0;
        end
    end

    always_comb begin
        rd_fields      = '0;
        rd_fields.cen  = cen_q;
        rd_fields.cec  = cec_q;
        rd_fields.ice  = ice_q;
        rd_fields.icc  = icc_q;
    end

    assign chcw_rd   = rd_fields;
    assign ice       = ice_q;
    assign icmaint   = icmaint_q;
    assign fetch_gnt = fetch_req & ~icmaint_q & ~clr_pend_q;

    always @(posedge CLK) begin
        if (RESn && CE) begin
            assert (!((state_q == S_CLEAR) && fill_tag_we));
            assert (!(icmaint && fetch_gnt));
        end
    end

endmodule

// File: doc/icache_maint_ctl.md
Name: icache_maint_ctl

Overview:
- Sequencer for I$ maintenance (CHCW ICC clear) and arbiter for the I$ tag RAM write port.
- Owns the architectural CHCW state: ICE, ICC, CEN, CEC.
- On an ICC request it waits for any in-flight fill to drain, then walks CEC tag entries from CEN, zeroing each. While it runs, it blocks new EU fetch grants.
- Sits between the EU (LDSR CHCW writes, fetch requests), the I$ fill logic and the itag RAM.

Parameters:
- TAGAW, 7, tag RAM address width (128 entries).
- TAGW, 28, tag entry width: 4 reserved + 2 subblock valid + 22 tag.
- CNTW, 12, width of the CEN and CEC fields.

Ports:
- CLK  in  1  system clock
- RESn  in  1  reset; one clock, reset is asynchronous and active-low
- CE  in  1  clock enable; all state advances only when CE=1
- chcw_we  in  1  EU write strobe for CHCW
- chcw_wd  in  32  write data: [0]=ICC, [1]=ICE, [19:8]=CEC, [31:20]=CEN
- chcw_rd  out  32  current CHCW readback, same field layout
- ice  out  1  cache enable to lookup logic
- icmaint  out  1  maintenance active; lookup must report miss
- fetch_req  in  1  EU instruction fetch request
- fetch_gnt  out  1  grant = fetch_req & ~icmaint & ~clr_pend
- fill_busy  in  1  fill engine has a line transfer in flight
- fill_tag_we  in  1  fill engine tag write
- fill_tag_a  in  TAGAW  fill tag address
- fill_tag_d  in  TAGW  fill tag data
- tag_we  out  1  to itag RAM
- tag_a  out  TAGAW  to itag RAM
- tag_d  out  TAGW  to itag RAM

Behaviour:
- Reset: state IDLE; ice=0; icmaint=0; clr_pend=0; CEN=CEC=0; ICC=0; tag_we=0; fetch_gnt=0.
- Asserting RESn low mid-clear aborts immediately. No further tag writes occur; RAM contents are left as is.
- States: IDLE, WAIT, CLEAR, DONE.
- IDLE, chcw_we with ICC=1: latch CEN and CEC, set ICC=1 and clr_pend=1, go to WAIT. ICE is latched from chcw_wd[1] on every accepted write.
- IDLE, chcw_we with ICC=0: update ICE only. CEN, CEC and ICC are unchanged (stay 0).
- WAIT: hold until fill_busy=0 and fill_tag_we=0 in the same CE cycle, then go to CLEAR and assert icmaint. No new grant is issued while clr_pend=1.
- CLEAR, each CE cycle with CEC!=0:
  - tag_we=1, tag_a=CEN[TAGAW-1:0], tag_d=0.
  - CEN<=CEN+1 (wraps mod 2^CNTW); CEC<=CEC-1.
  - The RAM index wraps mod 2^TAGAW.
- CLEAR with CEC==0: go to DONE. Latency for a clear of N entries is N+1 CE cycles from WAIT exit. CEC=0 on request gives 1 cycle with no RAM writes.
- DONE: ICC<=0, CEN<=0, CEC<=0, icmaint<=0, clr_pend<=0; go to IDLE next CE cycle.
- chcw_we while not IDLE: ICE is updated and the ICC/CEN/CEC fields are ignored. Neither a second clear nor a restart is allowed.
- Tag port mux: CLEAR has exclusive ownership. Otherwise fill_tag_* pass through combinationally.
- fill_tag_we asserted during CLEAR is a protocol violation. Assert-checked; the fill write is dropped.
- Invariant: icmaint implies ~fetch_gnt, checked every CE cycle.
- chcw_rd reflects live counter values during CLEAR. Bits 7:2 and the remaining unused bits read 0.

Decomposition:
- Shared package icache_pkg holds:
  - CHCW field bit positions and the chcw_t packed struct {cen, cec, rsvd, ice, icc}.
  - The tag entry typedef itag_t {rsvd[3:0], valid[1:0], tag[21:0]}.
  - TAGAW/TAGW/CNTW defaults.
- No sub-module. The tag-port mux is inline.

Test Plan:
- Write CHCW CEN=0, CEC=128, ICC=1 with RAM preloaded to all 1s. Required: exactly 128 tag_we pulses at addresses 0..127, all 128 entries 0, then ICC=CEN=CEC=0 and icmaint low 130 CE cycles after the write.
- Clear while fill_busy=1 for 5 CE cycles. Required: no tag_we from the clear until fill_busy drops; fetch_gnt=0 from the write onward; the fill's final tag write lands at its own address unmodified.
- CEN=126, CEC=4. Required: tag addresses 126, 127, 0, 1 cleared; entry 125 and entry 2 untouched; chcw_rd mid-clear shows CEC counting 4, 3, 2, 1.
- CEC=0, ICC=1. Required: no tag writes, icmaint pulses exactly 1 cycle, and ICC reads 0 afterwards.
- Write ICE=1 with ICC=0, then ICE=0 during a clear. Required: ice follows both writes; the clear completes unaffected; a second ICC request issued mid-clear is ignored.
- Drive RESn low at the 10th clear cycle. Required: ice=0, icmaint=0, ICC=0 asynchronously; no further tag_we; entries at the 10th address and beyond retain their preloaded value.
